pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, number of busy cycles for a multiply.
REQ-002 Parameter DIV_CYC, default 10, number of busy cycles for a divide.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 d_rs, d_rt  in  5 each  source register numbers of the instruction in D.
REQ-006 d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs rs/rt; 3 = not used.
REQ-007 e_wa, m_wa  in  5 each  destination register of the instructions in E/M; 0 = none.
REQ-008 e_tnew, m_tnew  in  2 each  cycles until the E/M result is forwardable.
REQ-009 d_md  in  1  D holds an MDU-class instruction (mult/div/mf*/mt*).
REQ-010 e_md_start, e_md_div  in  1 each  E launches an MDU op this cycle; 1 = divide, 0 = multiply.
REQ-011 req  in  1  exception/interrupt flush request from CP0.
REQ-012 stall  out  1  D must hold this cycle.
REQ-013 pc_en, if_id_en  out  1 each  enable for the PC and IF/ID registers.
REQ-014 id_ex_clr  out  1  insert a bubble into ID/EX.
REQ-015 md_busy  out  1  MDU occupied.
REQ-016 stall_cnt  out  32  count of stalled cycles, saturating.

Function
REQ-017 Data hazard: hz_e = (d_rs==e_wa && e_wa!=0 && d_tuse_rs<e_tnew), and likewise for rt; hz_m is the same test on m_wa/m_tnew.
REQ-018 MDU hazard: hz_md = d_md && (md_busy || e_md_start).
REQ-019 stall = (hz_e || hz_m || hz_md) && !req, combinational within the cycle.
REQ-020 pc_en = if_id_en = !stall; id_ex_clr = stall.
REQ-021 MDU FSM states: IDLE, MULT, DIV; 4-bit down-counter cnt.
REQ-022 IDLE with e_md_start && !req: go to DIV with cnt=DIV_CYC-1 if e_md_div, else MULT with cnt=MULT_CYC-1.
REQ-023 MULT/DIV: cnt decrements each cycle; at cnt==0 return to IDLE next cycle.
REQ-024 md_busy = (state!=IDLE), registered; it is high for exactly MULT_CYC or DIV_CYC cycles, beginning the cycle after the start.
REQ-025 e_md_start while not IDLE is illegal (hz_md prevents it); the FSM ignores it.
REQ-026 req in the same cycle as e_md_start suppresses the launch; req during MULT/DIV does not abort the operation.
REQ-027 stall_cnt increments by 1 on each cycle with stall=1 and saturates at 32'hFFFF_FFFF.

Reset
REQ-028 While reset=0: state=IDLE, cnt=0, md_busy=0, stall_cnt=0; stall, pc_en, if_id_en and id_ex_clr follow REQ-019/020 from their inputs.
REQ-029 Reset asserted mid-operation aborts the MDU op immediately, asynchronously, without waiting for a clock edge.

Structure
REQ-030 Shared package pipe_pkg holds the tuse/tnew 2-bit typedef, the MDU state enum, MULT_CYC/DIV_CYC defaults and the TUSE_NONE=3 constant.
REQ-031 The MDU FSM plus counter is one sub-module, md_busy_timer; hazard logic and stall_cnt stay in pipe_ctrl.

Verification
REQ-032 d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=1 -> stall=1, pc_en=0, id_ex_clr=1; with e_wa=0 instead -> stall=0.
REQ-033 e_md_start=1, e_md_div=0 at cycle T -> md_busy=1 for cycles T+1..T+5 only; with d_md=1 throughout, stall=1 for cycles T..T+5.
REQ-034 Divide start at T -> md_busy=1 for exactly 10 cycles; reset=0 at T+4 -> md_busy=0 at once, state IDLE.
REQ-035 req=1 together with hz_e=1 and e_md_start=1 -> stall=0, md_busy remains 0 on the next cycle.
REQ-036 stall_cnt preloaded by force to 32'hFFFF_FFFE, stall held 3 cycles -> reads FFFF_FFFF and holds there.
REQ-037 d_tuse_rs=3, d_rs=e_wa=7, e_tnew=2 -> stall=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
// Holds the tuse/tnew encoding, MDU state enum, default MDU latencies and
// a helper for the single-producer data-hazard test.
package pipe_pkg;

    // Cycles until a value is needed (tuse) or becomes forwardable (tnew).
    typedef logic [1:0] tuse_t;

    // A source whose tuse is TUSE_NONE is never read, so it never stalls:
    // no 2-bit tnew can exceed it.
    localparam tuse_t TUSE_NONE = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    typedef logic [3:0] md_cnt_t;

    // D-stage source 'rs' depends on a producer writing 'wa' whose result
    // arrives later than D needs it. Register 0 is never a real producer.
    function automatic logic src_hazard(input logic [4:0] rs, input tuse_t tuse,
                                        input logic [4:0] wa, input tuse_t tnew);
        return (rs == wa) && (wa != 5'd0) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard-detection inputs and stall-control outputs of pipe_ctrl.
// master: pipeline side driving D/E/M status; slave: the controller.
// Purely combinational wiring, no flow control of its own.
interface pipe_ctrl_if;
    import pipe_pkg::*;

    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    tuse_t       d_tuse_rs;
    tuse_t       d_tuse_rt;
    logic [4:0]  e_wa;
    logic [4:0]  m_wa;
    tuse_t       e_tnew;
    tuse_t       m_tnew;
    logic        d_md;
    logic        e_md_start;
    logic        e_md_div;
    logic        req;
    logic        stall;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_clr;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_wa, m_wa, e_tnew, m_tnew,
               d_md, e_md_start, e_md_div, req,
        input  stall, pc_en, if_id_en, id_ex_clr, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_wa, m_wa, e_tnew, m_tnew,
               d_md, e_md_start, e_md_div, req,
        output stall, pc_en, if_id_en, id_ex_clr, md_busy, stall_cnt
    );

endinterface

// File: rtl/md_busy_timer.sv
// MDU occupancy timer: IDLE/MULT/DIV FSM with a 4-bit down-counter.
// Latency: busy rises the cycle after start, stays high MULT_CYC/DIV_CYC cycles.
// Backpressure: none; start while busy or together with req is ignored.
// Ports: clk, reset (async active-low), start/div/req in, busy out (registered).
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    input  logic req,
    output logic busy
);

    localparam md_cnt_t MULT_INIT = md_cnt_t'(MULT_CYC - 1);
    localparam md_cnt_t DIV_INIT  = md_cnt_t'(DIV_CYC - 1);

    md_state_t state_q, state_d;
    md_cnt_t   cnt_q, cnt_d;
    logic      busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                // A flush in the launch cycle kills the MDU op before it starts.
                if (start && !req) begin
                    state_d = div ? MD_DIV : MD_MULT;
                    cnt_d   = div ? DIV_INIT : MULT_INIT;
                end
            end
            MD_MULT, MD_DIV: begin
                // Once launched, a flush does not abort the operation.
                if (cnt_q == '0) state_d = MD_IDLE;
                else             cnt_d   = cnt_q - md_cnt_t'(1);
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: data/MDU hazard detection, enables, stall counter.
// Latency: stall/enables combinational in the cycle; md_busy and stall_cnt registered.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; req overrides stall.
// Ports: clk, reset (async active-low), bus (pipe_ctrl_if.slave).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    pipe_ctrl_if.slave   bus
);

    logic        hz_e, hz_m, hz_md, stall;
    logic        md_busy;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (bus.e_md_start),
        .div   (bus.e_md_div),
        .req   (bus.req),
        .busy  (md_busy)
    );

    always_comb begin
        hz_e  = src_hazard(bus.d_rs, bus.d_tuse_rs, bus.e_wa, bus.e_tnew) ||
                src_hazard(bus.d_rt, bus.d_tuse_rt, bus.e_wa, bus.e_tnew);
        hz_m  = src_hazard(bus.d_rs, bus.d_tuse_rs, bus.m_wa, bus.m_tnew) ||
                src_hazard(bus.d_rt, bus.d_tuse_rt, bus.m_wa, bus.m_tnew);
        // An MDU-class op in D must wait while the MDU is (or is about to be) busy.
        hz_md = bus.d_md && (md_busy || bus.e_md_start);
        // A flush wins: D is about to be discarded anyway.
        stall = (hz_e || hz_m || hz_md) && !bus.req;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall     = stall;
    assign bus.pc_en     = !stall;
    assign bus.if_id_en  = !stall;
    assign bus.id_ex_clr = stall;
    assign bus.md_busy   = md_busy;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard vector table, directed MDU and
// saturation sequences, then random stimulus against a behavioural model.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.d_rs = 5'd0; bus.d_rt = 5'd0;
        bus.d_tuse_rs = TUSE_NONE; bus.d_tuse_rt = TUSE_NONE;
        bus.e_wa = 5'd0; bus.m_wa = 5'd0; bus.e_tnew = 2'd0; bus.m_tnew = 2'd0;
        bus.d_md = 1'b0; bus.e_md_start = 1'b0; bus.e_md_div = 1'b0; bus.req = 1'b0;
    endtask

    task automatic set_e_hazard();
        bus.d_rs = 5'd5; bus.d_tuse_rs = 2'd0; bus.e_wa = 5'd5; bus.e_tnew = 2'd1;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] trs, trt;
        logic [4:0] ewa;
        logic [1:0] etn;
        logic [4:0] mwa;
        logic [1:0] mtn;
        logic       rq;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    // Behavioural reference state
    int          md_rem;
    logic [31:0] m_cnt;
    logic        exp_stall;

    function automatic logic model_stall(input int rem);
        logic h;
        h = 1'b0;
        if (bus.e_wa != 0 && ((bus.d_rs == bus.e_wa && bus.d_tuse_rs < bus.e_tnew) ||
                              (bus.d_rt == bus.e_wa && bus.d_tuse_rt < bus.e_tnew))) h = 1'b1;
        if (bus.m_wa != 0 && ((bus.d_rs == bus.m_wa && bus.d_tuse_rs < bus.m_tnew) ||
                              (bus.d_rt == bus.m_wa && bus.d_tuse_rt < bus.m_tnew))) h = 1'b1;
        if (bus.d_md && (rem > 0 || bus.e_md_start)) h = 1'b1;
        return h && !bus.req;
    endfunction

    initial begin
        int busy_cycles;
        vecs[0] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1};
        vecs[1] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{5'd7, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{5'd1, 5'd9, 2'd3, 2'd1, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1};
        vecs[4] = '{5'd1, 5'd9, 2'd3, 2'd2, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd4, 2'd2, 1'b0, 1'b1};
        vecs[6] = '{5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0};
        vecs[7] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0};
        vecs[8] = '{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0};
        vecs[9] = '{5'd3, 5'd6, 2'd0, 2'd0, 5'd4, 2'd3, 5'd2, 2'd3, 1'b0, 1'b0};

        // ---- reset state; combinational outputs still follow inputs ----
        set_idle();
        set_e_hazard();
        #12;
        chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        @(posedge clk); #1;
        chk("rst_stall_cnt_hold", bus.stall_cnt, 32'd0);
        set_idle();
        @(negedge clk);
        reset = 1'b1;

        // ---- hazard vector table ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.d_rs = vecs[i].rs; bus.d_rt = vecs[i].rt;
            bus.d_tuse_rs = vecs[i].trs; bus.d_tuse_rt = vecs[i].trt;
            bus.e_wa = vecs[i].ewa; bus.e_tnew = vecs[i].etn;
            bus.m_wa = vecs[i].mwa; bus.m_tnew = vecs[i].mtn;
            bus.req = vecs[i].rq;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_pc_en", i), 32'(bus.pc_en), 32'(!vecs[i].exp_stall));
            chk($sformatf("vec%0d_if_id_en", i), 32'(bus.if_id_en), 32'(!vecs[i].exp_stall));
            chk($sformatf("vec%0d_id_ex_clr", i), 32'(bus.id_ex_clr), 32'(vecs[i].exp_stall));
        end

        // ---- multiply: busy T+1..T+5, stall T..T+5 with d_md held ----
        @(negedge clk);
        set_idle();
        bus.d_md = 1'b1; bus.e_md_start = 1'b1; bus.e_md_div = 1'b0;
        #1;
        chk("mul_T_stall", 32'(bus.stall), 32'd1);
        chk("mul_T_busy", 32'(bus.md_busy), 32'd0);
        @(negedge clk);
        bus.e_md_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("mul_T+%0d_busy", k), 32'(bus.md_busy), 32'(k <= 5));
            chk($sformatf("mul_T+%0d_stall", k), 32'(bus.stall), 32'(k <= 5));
            @(negedge clk);
        end

        // ---- flush with hazard and MDU launch: no stall, no launch ----
        set_idle();
        set_e_hazard();
        bus.e_md_start = 1'b1; bus.req = 1'b1;
        #1;
        chk("req_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        set_idle();
        #1;
        chk("req_no_launch", 32'(bus.md_busy), 32'd0);

        // ---- divide: busy for exactly 10 cycles (bounded) ----
        @(negedge clk);
        bus.e_md_start = 1'b1; bus.e_md_div = 1'b1;
        @(negedge clk);
        bus.e_md_start = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.md_busy) busy_cycles++;
            @(negedge clk);
        end
        chk("div_busy_cycles", 32'(busy_cycles), 32'd10);

        // ---- divide aborted by async reset at T+4 ----
        bus.e_md_start = 1'b1; bus.e_md_div = 1'b1;
        @(negedge clk);
        bus.e_md_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_busy_before", 32'(bus.md_busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy_now", 32'(bus.md_busy), 32'd0);
        chk("abort_state", 32'(dut.u_timer.state_q), 32'(MD_IDLE));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_stays_idle", 32'(bus.md_busy), 32'd0);

        // ---- stall_cnt saturation ----
        @(negedge clk);
        set_idle();
        set_e_hazard();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", bus.stall_cnt, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_cycle%0d", k), bus.stall_cnt, 32'hFFFF_FFFF);
        end

        // ---- random stimulus vs behavioural model ----
        @(negedge clk);
        set_idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        md_rem = 0;
        m_cnt  = 32'd0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.d_rs = 5'($urandom_range(0, 3));
            bus.d_rt = 5'($urandom_range(0, 3));
            bus.d_tuse_rs = 2'($urandom_range(0, 3));
            bus.d_tuse_rt = 2'($urandom_range(0, 3));
            bus.e_wa = 5'($urandom_range(0, 3));
            bus.m_wa = 5'($urandom_range(0, 3));
            bus.e_tnew = 2'($urandom_range(0, 3));
            bus.m_tnew = 2'($urandom_range(0, 3));
            bus.d_md = ($urandom_range(0, 3) == 0);
            bus.e_md_start = ($urandom_range(0, 5) == 0);
            bus.e_md_div = 1'($urandom);
            bus.req = ($urandom_range(0, 7) == 0);
            #1;
            exp_stall = model_stall(md_rem);
            chk("rnd_stall", 32'(bus.stall), 32'(exp_stall));
            chk("rnd_id_ex_clr", 32'(bus.id_ex_clr), 32'(exp_stall));
            chk("rnd_md_busy", 32'(bus.md_busy), 32'(md_rem > 0));
            chk("rnd_stall_cnt", bus.stall_cnt, m_cnt);
            @(posedge clk);
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (md_rem > 0) md_rem = md_rem - 1;
            else if (bus.e_md_start && !bus.req) md_rem = bus.e_md_div ? 10 : 5;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
